clk_reset_ctrl: RTL and testbench
=================================

CLK_RESET_CTRL -- requirements
Module: clk_reset_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on locked (range 2..4).
REQ-002 SHALL have parameter STABLE_CYCLES, default 16, consecutive synchronized-lock cycles required before reset release (range 1..65535).
REQ-003 SHALL have parameter HB_WIDTH, default 24, heartbeat counter width (heartbeat = counter MSB).
REQ-004 SHALL have port clk, input, 1, system clock (PLL output clock).
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous to clk, active-low.
REQ-006 SHALL have port locked, input, 1, PLL lock indicator, asynchronous to clk.
REQ-007 SHALL have port sys_rst_n, output, 1, sequenced active-low reset for downstream logic.
REQ-008 SHALL have port ready, output, 1, high while in RUN.
REQ-009 SHALL have port lock_lost, output, 1, one-cycle pulse on loss of lock during RUN.
REQ-010 SHALL have port loss_cnt, output, 8, saturating count of lock losses.
REQ-011 SHALL have port heartbeat, output, 1, LED blink while running.

Function
REQ-012 SHALL pass locked through SYNC_STAGES flops; only the last stage (lock_s) is used internally.
REQ-013 SHALL implement states WAIT_LOCK, STABLE, RUN, LOST, held in one state register.
REQ-014 WAIT_LOCK: lock_s=1 -> STABLE with stable counter cleared to 0; else stay.
REQ-015 STABLE: lock_s=0 -> WAIT_LOCK (counter cleared); lock_s=1 and counter=STABLE_CYCLES-1 -> RUN; otherwise counter +1.
REQ-016 RUN: lock_s=0 -> LOST; else stay.
REQ-017 LOST: unconditionally -> WAIT_LOCK after exactly one cycle.
REQ-018 sys_rst_n and ready SHALL be 1 iff state register = RUN (decoded from a register, no combinational path from locked).
REQ-019 Counting the first edge sampling locked=1 as edge 1, sys_rst_n SHALL rise after edge SYNC_STAGES+STABLE_CYCLES+1, given locked stays high (19 with defaults).
REQ-020 lock_lost SHALL be 1 exactly during the LOST cycle.
REQ-021 loss_cnt SHALL increment by 1 on each RUN->LOST transition, saturating at 255 (no wrap).
REQ-022 A lock glitch (lock_s low for any cycle) in STABLE SHALL restart the full STABLE_CYCLES qualification.
REQ-023 A lock drop shorter than one clk period that is never sampled low SHALL have no effect.

Reset
REQ-024 rst_n=0 at a clk edge SHALL override all other conditions: state=WAIT_LOCK, synchronizer flops=0, stable counter=0, loss_cnt=0, heartbeat counter=0.
REQ-025 Output reset values: sys_rst_n=0, ready=0, lock_lost=0, loss_cnt=0, heartbeat=0.
REQ-026 rst_n asserted mid-STABLE or in RUN SHALL drop sys_rst_n at the next edge and SHALL NOT increment loss_cnt.
REQ-027 After rst_n release, full synchronization plus qualification (REQ-019) SHALL apply again.

Configuration
REQ-028 With macro CLK_RESET_CTRL_HEARTBEAT_EN defined: HB_WIDTH-bit counter increments each cycle in RUN, clears to 0 in every other state; heartbeat = counter MSB.
REQ-029 Without CLK_RESET_CTRL_HEARTBEAT_EN: no heartbeat counter is built; heartbeat is constant 0.

Structure
REQ-030 Shared package SHALL hold the state enumeration (WAIT_LOCK, STABLE, RUN, LOST) and the loss_cnt width constant (8).
REQ-031 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, reset value 0), instantiated once.
REQ-032 Stable counter width SHALL be the minimum covering STABLE_CYCLES-1 (min 1 bit).

Verification
REQ-033 Defaults, rst_n released, locked driven high at edge 1 -> sys_rst_n=0 through edge 18, sys_rst_n=1 and ready=1 after edge 19.
REQ-034 In STABLE, locked low for 3 cycles at stable count 10 -> return to WAIT_LOCK; sys_rst_n rises only after a further full 16-cycle qualification.
REQ-035 In RUN, locked dropped for 5 cycles -> lock_lost=1 for one cycle, loss_cnt 0->1, sys_rst_n=0 next edge; re-lock -> release 19 edges after re-lock.
REQ-036 300 lock-loss cycles -> loss_cnt holds at 255, no wrap to 0.
REQ-037 rst_n pulled low for 1 cycle while in RUN -> all outputs at reset values next edge, loss_cnt=0, lock_lost never pulses.
REQ-038 HB_WIDTH=4 with CLK_RESET_CTRL_HEARTBEAT_EN -> heartbeat toggles every 8 cycles in RUN, 0 outside RUN; without macro -> heartbeat constantly 0.

Source files
------------

// File: rtl/clk_reset_ctrl_pkg.sv
// clk_reset_ctrl_pkg: shared state encoding, loss counter width and counter sizing helper
package clk_reset_ctrl_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN, LOST} state_t;
  localparam int LOSS_W = 8;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_reset_ctrl_sync_ff.sv
// sync_ff: multi-flop synchronizer for a single asynchronous bit, clears to 0 on reset
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_ff;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (!rst_n) r_ff <= '0;
    else r_ff <= {r_ff[STAGES-2:0], i_d};
  end
  assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/clk_reset_ctrl.sv
// clk_reset_ctrl: PLL lock qualification and reset sequencing; heartbeat built only with CLK_RESET_CTRL_HEARTBEAT_EN
module clk_reset_ctrl
  import clk_reset_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int HB_WIDTH      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_cnt,
  output logic              heartbeat
);
  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 || HB_WIDTH < 1) begin : g_param_err
    $error("clk_reset_ctrl: parameter out of range");
  end

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [LOSS_W-1:0] r_loss;
  logic              w_lock_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (locked),
    .o_q  (w_lock_s)
  );

  // state, qualification counter and saturating loss counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_loss  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == RUN && !w_lock_s && r_loss != '1) r_loss <= r_loss + 1'b1;
    end
  end

  // next state: any low lock sample restarts qualification from zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      WAIT_LOCK: w_state_nxt = w_lock_s ? STABLE : WAIT_LOCK;
      STABLE: begin
        w_state_nxt = !w_lock_s ? WAIT_LOCK : (r_cnt == LAST) ? RUN : STABLE;
        w_cnt_nxt   = (w_lock_s && r_cnt != LAST) ? r_cnt + 1'b1 : '0;
      end
      RUN:     w_state_nxt = w_lock_s ? RUN : LOST;
      LOST:    w_state_nxt = WAIT_LOCK;
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  assign sys_rst_n = (r_state == RUN);
  assign ready     = (r_state == RUN);
  assign lock_lost = (r_state == LOST);
  assign loss_cnt  = r_loss;

`ifdef CLK_RESET_CTRL_HEARTBEAT_EN
  logic [HB_WIDTH-1:0] r_hb;
  // free-running blink counter, held at zero outside RUN
  always_ff @(posedge clk) begin
    if (!rst_n) r_hb <= '0;
    else r_hb <= (r_state == RUN) ? r_hb + 1'b1 : '0;
  end
  assign heartbeat = r_hb[HB_WIDTH-1];
`else
  assign heartbeat = 1'b0;
`endif
endmodule

// File: tb/tb_clk_reset_ctrl.sv
// tb_clk_reset_ctrl: directed self-checking bench for clk_reset_ctrl (SYNC_STAGES=2, STABLE_CYCLES=16, HB_WIDTH=4)
module tb_clk_reset_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       sys_rst_n, ready, lock_lost, heartbeat;
  logic [7:0] loss_cnt;
  int         errors = 0;
  int         checks = 0;

  clk_reset_ctrl #(.SYNC_STAGES(2), .STABLE_CYCLES(16), .HB_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .locked   (locked),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .lock_lost(lock_lost),
    .loss_cnt (loss_cnt),
    .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    locked = 1'b0;
    edge_step();
    edge_step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    locked = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      checks++;
      if ({sys_rst_n, ready, lock_lost, heartbeat, loss_cnt} !== 12'h000) begin
        errors++;
        $display("FAIL reset: got sys_rst_n=%b ready=%b lock_lost=%b hb=%b loss_cnt=%0d, want all 0",
                 sys_rst_n, ready, lock_lost, heartbeat, loss_cnt);
      end
    end
    locked = 1'b0;
    edge_step();
    rst_n = 1'b1;
  endtask

  task automatic test_release();
    locked = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      edge_step();
      checks++;
      if (sys_rst_n !== (k >= 19) || ready !== (k >= 19) || lock_lost !== 1'b0) begin
        errors++;
        $display("FAIL release edge %0d: sys_rst_n=%b ready=%b lock_lost=%b, want %b %b 0",
                 k, sys_rst_n, ready, lock_lost, k >= 19, k >= 19);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 1; k <= 37; k++) begin
      locked = (k >= 14 && k <= 16) ? 1'b0 : 1'b1;
      edge_step();
      checks++;
      if (sys_rst_n !== (k >= 35) || ready !== (k >= 35)) begin
        errors++;
        $display("FAIL stable_glitch edge %0d: sys_rst_n=%b ready=%b, want %b", k, sys_rst_n, ready, k >= 35);
      end
    end
  endtask

  task automatic test_loss();
    for (int k = 1; k <= 25; k++) begin
      locked = (k <= 5) ? 1'b0 : 1'b1;
      edge_step();
      checks++;
      if (lock_lost !== (k == 3) || sys_rst_n !== (k < 3 || k >= 24) || loss_cnt !== ((k >= 3) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL lock_loss edge %0d: lock_lost=%b sys_rst_n=%b loss_cnt=%0d, want %b %b %0d",
                 k, lock_lost, sys_rst_n, loss_cnt, k == 3, k < 3 || k >= 24, (k >= 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b0;
      edge_step();
      locked = 1'b1;
      for (int k = 0; k < 25; k++) edge_step();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (loss_cnt !== 8'(exp_cnt) || ready !== 1'b1) begin
        errors++;
        $display("FAIL saturate iter %0d: loss_cnt=%0d ready=%b, want %0d 1", i, loss_cnt, ready, exp_cnt);
      end
    end
  endtask

  task automatic test_short_drop();
    for (int k = 0; k < 5; k++) begin
      #1 locked = 1'b0;
      #2 locked = 1'b1;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || lock_lost !== 1'b0 || loss_cnt !== 8'd255) begin
        errors++;
        $display("FAIL short_drop %0d: ready=%b lock_lost=%b loss_cnt=%0d, want 1 0 255", k, ready, lock_lost, loss_cnt);
      end
    end
  endtask

  task automatic test_reset_in_run();
    rst_n = 1'b0;
    edge_step();
    checks++;
    if ({sys_rst_n, ready, lock_lost, heartbeat, loss_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL run_reset: got sys_rst_n=%b ready=%b lock_lost=%b hb=%b loss_cnt=%0d, want all 0",
               sys_rst_n, ready, lock_lost, heartbeat, loss_cnt);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      edge_step();
      checks++;
      if (lock_lost !== 1'b0 || loss_cnt !== 8'd0 || sys_rst_n !== (k >= 19)) begin
        errors++;
        $display("FAIL run_reset_requal edge %0d: lock_lost=%b loss_cnt=%0d sys_rst_n=%b, want 0 0 %b",
                 k, lock_lost, loss_cnt, sys_rst_n, k >= 19);
      end
    end
  endtask

  task automatic test_heartbeat();
    logic [7:0] c;
    logic       exp_hb;
    do_reset();
    locked = 1'b1;
    for (int k = 1; k <= 59; k++) begin
      edge_step();
      c = (k >= 19) ? 8'(k - 19) : 8'd0;
`ifdef CLK_RESET_CTRL_HEARTBEAT_EN
      exp_hb = c[3];
`else
      exp_hb = 1'b0;
`endif
      checks++;
      if (heartbeat !== exp_hb) begin
        errors++;
        $display("FAIL heartbeat edge %0d: got %b want %b", k, heartbeat, exp_hb);
      end
    end
    locked = 1'b0;
    for (int k = 1; k <= 6; k++) edge_step();
    checks++;
    if (heartbeat !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL heartbeat_off: hb=%b ready=%b, want 0 0", heartbeat, ready);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_release();
    test_glitch();
    test_loss();
    test_saturate();
    test_short_drop();
    test_reset_in_run();
    test_heartbeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
